// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the fp32 multiplier datapath.
//   fp32_t       : packed binary32 view {sign, exp, frac}
//   sp_t         : special-case code produced by the classify stage
//   FLG_*        : bit positions inside the 4-bit flag vector {inv, ovf, unf, zero}
//   classify()   : operand-pair special-case detection, subnormals flushed to zero
package fp_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   localparam int          FP32_BIAS    = 127;
   localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;
   localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;

   localparam int FLG_INV  = 3;
   localparam int FLG_OVF  = 2;
   localparam int FLG_UNF  = 1;
   localparam int FLG_ZERO = 0;

   typedef enum logic [1:0] {
      SP_NONE = 2'd0,   // both operands normal: use the mantissa product
      SP_ZERO = 2'd1,   // signed zero result
      SP_INF  = 2'd2,   // signed infinity result
      SP_NAN  = 2'd3    // canonical quiet NaN, invalid
   } sp_t;

   // Priority: subnormals count as zero, then NaN / inf*0, then inf, then zero.
   function automatic sp_t classify(input fp32_t x, input fp32_t y);
      logic zx, zy, ix, iy, nx, ny;
      zx = (x.exp == 8'h00);
      zy = (y.exp == 8'h00);
      ix = (x.exp == FP32_EXP_MAX) && (x.frac == 23'd0);
      iy = (y.exp == FP32_EXP_MAX) && (y.frac == 23'd0);
      nx = (x.exp == FP32_EXP_MAX) && (x.frac != 23'd0);
      ny = (y.exp == FP32_EXP_MAX) && (y.frac != 23'd0);
      if (nx | ny)                      return SP_NAN;
      else if ((ix & zy) | (zx & iy))   return SP_NAN;
      else if (ix | iy)                 return SP_INF;
      else if (zx | zy)                 return SP_ZERO;
      else                              return SP_NONE;
   endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: combinational normalise / round / pack stage.
//   Build option: FP_MUL_RNE_EN defined selects round-to-nearest-even,
//   otherwise the fraction is truncated (round toward zero).
// Ports:
//   p       in   48  raw 24x24 mantissa product
//   exp_in  in   10  signed biased exponent sum ea+eb-bias
//   sign    in   1   result sign sa^sb
//   sp      in   2   special-case code from the classify stage
//   res     out  32  packed fp32 result
//   flags   out  4   {inv, ovf, unf, zero}
module fp_mul_norm_round
   import fp_pkg::*;
(
   input  logic [47:0]       p,
   input  logic signed [9:0] exp_in,
   input  logic              sign,
   input  sp_t               sp,
   output logic [31:0]       res,
   output logic [3:0]        flags
);

   logic [22:0]       frac;
   logic              guard;
   logic              sticky;
   logic signed [9:0] e;

   always_comb begin
      frac   = '0;
      guard  = 1'b0;
      sticky = 1'b0;
      e      = exp_in;
      res    = '0;
      flags  = '0;

      // Product of two [1,2) mantissas lies in [1,4); bit 47 means >= 2.
      if (p[47]) begin
         frac   = p[46:24];
         guard  = p[23];
         sticky = |p[22:0];
         e      = exp_in + 10'sd1;
      end else begin
         frac   = p[45:23];
         guard  = p[22];
         sticky = |p[21:0];
      end

`ifdef FP_MUL_RNE_EN
      if (guard & (sticky | frac[0])) begin
         // All-ones fraction rolls over to zero and bumps the exponent.
         if (frac == 23'h7F_FFFF) begin
            frac = '0;
            e    = e + 10'sd1;
         end else begin
            frac = frac + 23'd1;
         end
      end
`endif

      case (sp)
         SP_NAN: begin
            res            = FP32_QNAN;
            flags[FLG_INV] = 1'b1;
         end
         SP_INF: begin
            res = {sign, FP32_EXP_MAX, 23'd0};
         end
         SP_ZERO: begin
            res             = {sign, 31'd0};
            flags[FLG_ZERO] = 1'b1;
         end
         default: begin
            if (e >= 10'sd255) begin
               res            = {sign, FP32_EXP_MAX, 23'd0};
               flags[FLG_OVF] = 1'b1;
            end else if (e <= 10'sd0) begin
               res             = {sign, 31'd0};
               flags[FLG_UNF]  = 1'b1;
               flags[FLG_ZERO] = 1'b1;
            end else begin
               res = {sign, e[7:0], frac};
            end
         end
      endcase
   end

`ifndef FP_MUL_RNE_EN
   // Truncation ignores the rounding bits.
   logic unused_rnd;
   assign unused_rnd = guard | sticky;
`endif

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined IEEE-754 binary32 multiplier with sideband tag.
//   S1 unpack/classify, S2 mantissa multiply + exponent sum, S3 normalise/round/pack.
//   Build option: FP_MUL_RNE_EN (round-to-nearest-even; default truncation).
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   in_valid   in   1      a/b/in_tag valid
//   in_ready   out  1      operand pair accepted this cycle when in_valid
//   a, b       in   32     fp32 operands
//   in_tag     in   TAG_W  sideband travelling with the pair
//   out_valid  out  1      prod/out_tag/out_flags valid
//   out_ready  in   1      downstream accepts the result
//   prod       out  32     fp32 product
//   out_tag    out  TAG_W  tag of the producing pair
//   out_flags  out  4      {inv, ovf, unf, zero}
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      a,
   input  logic [31:0]      b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      prod,
   output logic [TAG_W-1:0] out_tag,
   output logic [3:0]       out_flags
);

   // Handshake: a pair transfers in when in_valid & in_ready; a result
   // transfers out when out_valid & out_ready. A held result (out_valid &
   // ~out_ready) freezes every stage, so in_ready drops combinationally and
   // all outputs stay stable until downstream takes the result.
   logic stall;
   logic adv;

   assign stall    = out_valid & ~out_ready;
   assign adv      = ~stall;
   assign in_ready = ~stall;

   fp32_t fa, fb;
   assign fa = fp32_t'(a);
   assign fb = fp32_t'(b);

   // S1 registers
   logic             s1_valid;
   logic             s1_sign;
   logic [7:0]       s1_ea, s1_eb;
   logic [23:0]      s1_ma, s1_mb;
   sp_t              s1_sp;
   logic [TAG_W-1:0] s1_tag;

   // S2 registers
   logic              s2_valid;
   logic              s2_sign;
   logic [47:0]       s2_p;
   logic signed [9:0] s2_exp;
   sp_t               s2_sp;
   logic [TAG_W-1:0]  s2_tag;

   // S3 combinational result
   logic [31:0] s3_res;
   logic [3:0]  s3_flags;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_ea    <= '0;
         s1_eb    <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s1_sp    <= SP_NONE;
         s1_tag   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= fa.sign ^ fb.sign;
            s1_ea   <= fa.exp;
            s1_eb   <= fb.exp;
            s1_ma   <= {1'b1, fa.frac};
            s1_mb   <= {1'b1, fb.frac};
            s1_sp   <= classify(fa, fb);
            s1_tag  <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_p     <= '0;
         s2_exp   <= '0;
         s2_sp    <= SP_NONE;
         s2_tag   <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_sign <= s1_sign;
            s2_p    <= 48'(s1_ma) * 48'(s1_mb);
            // Range -125..381 fits a 10-bit signed value.
            s2_exp  <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb})
                       - $signed(10'(FP32_BIAS));
            s2_sp   <= s1_sp;
            s2_tag  <= s1_tag;
         end
      end
   end

   fp_mul_norm_round u_norm (
      .p      (s2_p),
      .exp_in (s2_exp),
      .sign   (s2_sign),
      .sp     (s2_sp),
      .res    (s3_res),
      .flags  (s3_flags)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         prod      <= '0;
         out_tag   <= '0;
         out_flags <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            prod      <= s3_res;
            out_tag   <= s2_tag;
            out_flags <= s3_flags;
         end
      end
   end

endmodule
